// File: rtl/linear_mac_engine.sv
// Sequential matrix multiply-accumulate engine: out = sat((mat_a x wt) >>> FRAC_BITS + bias),
// one output row per pass through MATRIX_SIZE parallel multipliers, behind a start/done/clear handshake.
module linear_mac_engine #(
  parameter int MATRIX_SIZE = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int FRAC_BITS   = 4,
  parameter int ACC_WIDTH   = 2*DATA_WIDTH + $clog2(MATRIX_SIZE) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] mat_a      [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1],
  input  logic signed [DATA_WIDTH-1:0] wt         [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1],
  input  logic signed [DATA_WIDTH-1:0] bias       [0:MATRIX_SIZE-1],
  output logic signed [DATA_WIDTH-1:0] out_matrix [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1],
  output logic                         done,
  output logic                         busy
);

  localparam int IDX_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(MATRIX_SIZE - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'(2**(DATA_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH+1)'(-(2**(DATA_WIDTH-1)));

  typedef enum logic [2:0] {IDLE, MAC, WB, DONE, HOLD} state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               i_q, i_d, k_q, k_d;
  logic signed [ACC_WIDTH-1:0]    acc_q [0:MATRIX_SIZE-1];
  logic signed [ACC_WIDTH-1:0]    acc_d [0:MATRIX_SIZE-1];
  logic signed [DATA_WIDTH-1:0]   out_q [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1];
  logic signed [DATA_WIDTH-1:0]   out_d [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1];
  logic                           done_q, done_d, busy_q, busy_d;
  logic signed [2*DATA_WIDTH-1:0] prod  [0:MATRIX_SIZE-1];

  // Floor-shift the dot product, then add the sign-extended bias one bit wider than acc.
  function automatic logic signed [ACC_WIDTH:0] scale_bias(
    input logic signed [ACC_WIDTH-1:0]  acc,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [ACC_WIDTH-1:0] shifted;
    shifted = acc >>> FRAC_BITS;
    return (ACC_WIDTH+1)'(shifted) + (ACC_WIDTH+1)'(b);
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat_dw(input logic signed [ACC_WIDTH:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return v[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    for (int j = 0; j < MATRIX_SIZE; j++) begin
      prod[j] = mat_a[i_q][k_q] * wt[k_q][j];
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    k_d     = k_q;
    acc_d   = acc_q;
    out_d   = out_q;
    if (clear) begin
      state_d = IDLE;
      i_d     = '0;
      k_d     = '0;
      for (int j = 0; j < MATRIX_SIZE; j++) acc_d[j] = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = MAC;
            i_d     = '0;
            k_d     = '0;
            for (int j = 0; j < MATRIX_SIZE; j++) acc_d[j] = '0;
          end
        end
        MAC: begin
          if (!start) begin
            state_d = IDLE;
            i_d     = '0;
            k_d     = '0;
            for (int j = 0; j < MATRIX_SIZE; j++) acc_d[j] = '0;
          end else begin
            for (int j = 0; j < MATRIX_SIZE; j++) acc_d[j] = acc_q[j] + ACC_WIDTH'(prod[j]);
            if (k_q == LAST) begin
              state_d = WB;
              k_d     = '0;
            end else begin
              k_d = k_q + IDX_W'(1);
            end
          end
        end
        WB: begin
          // A falling start here aborts before the row is committed.
          if (!start) begin
            state_d = IDLE;
            i_d     = '0;
            k_d     = '0;
            for (int j = 0; j < MATRIX_SIZE; j++) acc_d[j] = '0;
          end else begin
            for (int j = 0; j < MATRIX_SIZE; j++) begin
              out_d[i_q][j] = sat_dw(scale_bias(acc_q[j], bias[j]));
              acc_d[j]      = '0;
            end
            k_d = '0;
            if (i_q == LAST) begin
              state_d = DONE;
            end else begin
              i_d     = i_q + IDX_W'(1);
              state_d = MAC;
            end
          end
        end
        DONE:    state_d = HOLD;
        HOLD:    if (!start) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    done_d = (state_d == DONE);
    busy_d = (state_d == MAC) || (state_d == WB);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int j = 0; j < MATRIX_SIZE; j++) begin
        acc_q[j] <= '0;
        for (int c = 0; c < MATRIX_SIZE; c++) out_q[j][c] <= '0;
      end
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      k_q     <= k_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  assign out_matrix = out_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_linear_mac_engine.sv
// Directed bench for linear_mac_engine: handshake timing, arithmetic corners, clear/abort/reset behaviour.
module tb_linear_mac_engine;
  localparam int N  = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n, start, clear;
  logic signed [DW-1:0] a    [0:N-1][0:N-1];
  logic signed [DW-1:0] w    [0:N-1][0:N-1];
  logic signed [DW-1:0] b    [0:N-1];
  logic signed [DW-1:0] outm [0:N-1][0:N-1];
  logic done, busy;
  int   exp_m [0:N-1][0:N-1];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  linear_mac_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .mat_a(a), .wt(w), .bias(b), .out_matrix(outm), .done(done), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic set_ops(input int av, input int wv, input int bv);
    for (int r = 0; r < N; r++) begin
      b[r] = DW'(bv);
      for (int c = 0; c < N; c++) begin
        a[r][c] = DW'(av);
        w[r][c] = DW'(wv);
      end
    end
  endtask

  task automatic fill_exp(input int v);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) exp_m[r][c] = v;
  endtask

  task automatic check_out(input string tag);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        chk($sformatf("%s_out[%0d][%0d]", tag, r, c), int'(outm[r][c]), exp_m[r][c]);
  endtask

  // Expects IDLE with start high at the next edge; done must appear 273 cycles later.
  task automatic run_op(input string tag);
    int dc;
    dc = -1;
    for (int n = 1; n <= 300 && dc < 0; n++) begin
      tick();
      if (done) dc = n;
      chk($sformatf("%s_busy_c%0d", tag, n), int'(busy), (n <= 272) ? 1 : 0);
    end
    chk({tag, "_done_cycle"}, dc, 273);
  endtask

  // From DONE: one cycle into HOLD, one more to IDLE.
  task automatic go_idle();
    start = 1'b0;
    tick();
    tick();
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0;
    set_ops(0, 0, 0);
    tick();
    tick();
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    fill_exp(0);
    check_out("rst");
    rst_n = 1'b1;

    // Uniform product: 16 * 2 * 8 = 256, >>> 4 = 16
    set_ops(2, 8, 0);
    start = 1'b1;
    run_op("uni");
    fill_exp(16);
    check_out("uni");

    // Start held after done: no retrigger, output held
    for (int n = 0; n < 5; n++) begin
      tick();
      chk($sformatf("hold_done%0d", n), int'(done), 0);
      chk($sformatf("hold_busy%0d", n), int'(busy), 0);
      chk($sformatf("hold_out%0d", n), int'(outm[3][7]), 16);
    end

    // Clear with start still high re-arms; start then wins in IDLE
    set_ops(127, 127, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy", int'(busy), 0);
    chk("clr_done", int'(done), 0);
    run_op("satp");
    fill_exp(127);
    check_out("satp");

    go_idle();
    set_ops(-128, 127, 0);
    start = 1'b1;
    run_op("satn");
    fill_exp(-128);
    check_out("satn");

    // Floor rounding: -1 >>> 4 = -1, plus bias j
    go_idle();
    set_ops(0, 1, 0);
    a[0][0] = -8'sd1;
    for (int c = 0; c < N; c++) b[c] = DW'(c);
    start = 1'b1;
    run_op("floor");
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) exp_m[r][c] = (r == 0) ? c - 1 : c;
    check_out("floor");

    go_idle();
    set_ops(1, 5, 0);
    start = 1'b1;
    run_op("five");
    fill_exp(5);
    check_out("five");

    // Clear at cycle 100: rows 0..4 written (last WB at 85), rows 5..15 untouched
    go_idle();
    set_ops(2, 8, 0);
    start = 1'b1;
    for (int n = 1; n <= 100; n++) tick();
    clear = 1'b1;
    start = 1'b0;
    tick();
    clear = 1'b0;
    chk("mclr_busy", int'(busy), 0);
    chk("mclr_done", int'(done), 0);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk($sformatf("mclr_nodone%0d", n), int'(done), 0);
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) exp_m[r][c] = (r <= 4) ? 16 : 5;
    check_out("mclr");
    start = 1'b1;
    run_op("after_clr");
    fill_exp(16);
    check_out("after_clr");

    // Start dropped at cycle 40: rows 0,1 written (WB at 17, 34), rest keep 16
    go_idle();
    set_ops(1, 5, 0);
    start = 1'b1;
    for (int n = 1; n <= 40; n++) tick();
    start = 1'b0;
    tick();
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk($sformatf("abort_nodone%0d", n), int'(done), 0);
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) exp_m[r][c] = (r <= 1) ? 5 : 16;
    check_out("abort");

    // Reset at cycle 150 clears everything including out_matrix
    set_ops(-128, 127, 0);
    start = 1'b1;
    for (int n = 1; n <= 150; n++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_done", int'(done), 0);
    chk("mrst_busy", int'(busy), 0);
    fill_exp(0);
    check_out("mrst");
    set_ops(1, 5, 0);
    run_op("after_rst");
    fill_exp(5);
    check_out("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
